pll_reset_sequencer: RTL and testbench

- Reset/lock sequencer that sits directly upstream of pll_xilinx and drives its RST input.
- Runs on the board reference clock, the same clock that feeds pll_xilinx clk_in.
- Sequence: pulses PLL reset, waits for LOCKED, qualifies lock stability, then releases the system reset for the Mandelbrot core.
- Monitors lock after release; on loss of lock it re-asserts system reset and restarts the PLL.

---
 rtl/pll_reset_sequencer.sv | 125 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification and system reset release
// Optional feature: define PLL_RETRY_COUNT_EN for a saturating retry_count; otherwise it reads 0.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] retry_count
);

    localparam logic [1:0] RESET_PLL = 2'd0;
    localparam logic [1:0] WAIT_LOCK = 2'd1;
    localparam logic [1:0] STABLE    = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    logic             sync_q1;
    logic             lock_s;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             loss_ev;

    // pll_locked comes from the PLL's own lock detector, asynchronous to clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            sync_q1 <= pll_locked;
            lock_s  <= sync_q1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        loss_ev   = 1'b0;
        case (state)
            RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                // lock takes priority over a timeout landing on the same cycle
                if (lock_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt = RESET_PLL;
                    cnt_nxt   = '0;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (!lock_s) begin
                    state_nxt = RESET_PLL;
                    loss_ev   = 1'b1;
                end
            end
            default: begin
                state_nxt = RESET_PLL;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they move on the same edge as the FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pll_rst   <= (state_nxt == RESET_PLL);
            sys_rst   <= (state_nxt != RUN);
            ready     <= (state_nxt == RUN);
            lock_lost <= loss_ev;
        end
    end

`ifdef PLL_RETRY_COUNT_EN
    logic retry_ev;
    assign retry_ev = (state == WAIT_LOCK) && !lock_s && (cnt == TIMEOUT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_count <= 8'd0;
        end else if ((retry_ev || loss_ev) && (retry_count != 8'hFF)) begin
            retry_count <= retry_count + 8'd1;
        end
    end
`else
    assign retry_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer against a phase/elapsed-time model
module tb_pll_reset_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic [7:0] retry_count;

    int compared   = 0;
    int mismatched = 0;
    bit pll_rst_seen = 1'b0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (17)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .retry_count(retry_count)
    );

    // Reference: which phase the sequencer is in and how long it has been there
    typedef enum {PH_PULSE, PH_WAIT, PH_QUAL, PH_RUN} phase_t;
    phase_t ph      = PH_PULSE;
    int     elapsed = 0;
    int     retries = 0;
    bit     lost    = 1'b0;
    bit     hist1   = 1'b0;
    bit     hist2   = 1'b0;
    bit     seen    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = PH_PULSE; elapsed = 0; retries = 0; lost = 1'b0; hist1 = 1'b0; hist2 = 1'b0;
        end else begin
            seen = hist2;
            hist2 = hist1;
            hist1 = pll_locked;
            lost = 1'b0;
            elapsed++;
            case (ph)
                PH_PULSE: if (elapsed == RST_CYCLES) begin ph = PH_WAIT; elapsed = 0; end
                PH_WAIT: begin
                    if (seen) begin ph = PH_QUAL; elapsed = 0; end
                    else if (elapsed == LOCK_TIMEOUT) begin ph = PH_PULSE; elapsed = 0; retries++; end
                end
                PH_QUAL: begin
                    if (!seen) begin ph = PH_WAIT; elapsed = 0; end
                    else if (elapsed == STABLE_CYCLES) begin ph = PH_RUN; elapsed = 0; end
                end
                PH_RUN: if (!seen) begin ph = PH_PULSE; elapsed = 0; lost = 1'b1; retries++; end
            endcase
        end
    end

    function automatic int exp_retry();
`ifdef PLL_RETRY_COUNT_EN
        return (retries > 255) ? 255 : retries;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("pll_rst",     32'(pll_rst),     32'(ph == PH_PULSE));
        chk("sys_rst",     32'(sys_rst),     32'(ph != PH_RUN));
        chk("ready",       32'(ready),       32'(ph == PH_RUN));
        chk("lock_lost",   32'(lock_lost),   32'(lost));
        chk("retry_count", 32'(retry_count), 32'(exp_retry()));
    endtask

    task automatic check_reset_values(input string where);
        chk({where, "_pll_rst"},   32'(pll_rst),     32'd1);
        chk({where, "_sys_rst"},   32'(sys_rst),     32'd1);
        chk({where, "_ready"},     32'(ready),       32'd0);
        chk({where, "_lock_lost"}, 32'(lock_lost),   32'd0);
        chk({where, "_retry"},     32'(retry_count), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pll_rst === 1'b1) pll_rst_seen = 1'b1;
        check_model();
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return pll_rst;
            1:       return sys_rst;
            default: return ready;
        endcase
    endfunction

    // Ticks until the selected output reaches val; n = budget when it never does
    task automatic ticks_until(input int sel, input logic val, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (sig(sel) !== val && n < budget);
    endtask

    int n;
    int r0;
    int len;

    initial begin
        repeat (3) tick();
        check_reset_values("in_reset");
        rst = 1'b0;

        ticks_until(0, 1'b0, 50, n);
        chk("powerup_pll_rst_width", n, RST_CYCLES);
        repeat (6) tick();
        pll_locked = 1'b1;
        ticks_until(1, 1'b0, 100, n);
        chk("release_latency_edges", n - 1, STABLE_CYCLES + 2);
        chk("ready_after_release", 32'(ready), 32'd1);
        repeat (5) tick();
        chk("ready_holds", 32'(ready), 32'd1);

        pll_locked = 1'b0;
        ticks_until(1, 1'b1, 20, n);
        chk("loss_latency_edges", n, 3);
        chk("loss_pll_rst", 32'(pll_rst), 32'd1);
        chk("loss_lock_lost_pulse", 32'(lock_lost), 32'd1);
        tick();
        chk("loss_lock_lost_width", 32'(lock_lost), 32'd0);

        ticks_until(0, 1'b0, 20, n);
        chk("loss_pll_rst_rest", n, RST_CYCLES - 1);
        pll_locked = 1'b1;
        repeat (7) tick();
        pll_locked = 1'b0;
        pll_rst_seen = 1'b0;
        tick();
        pll_locked = 1'b1;
        ticks_until(1, 1'b0, 100, n);
        chk("requal_latency", n, STABLE_CYCLES + 3);
        chk("glitch_no_pll_rst", 32'(pll_rst_seen), 32'd0);

        pll_locked = 1'b0;
        ticks_until(1, 1'b1, 20, n);
        ticks_until(0, 1'b0, 20, n);
        r0 = exp_retry();
        repeat (29) tick();
        pll_locked = 1'b1;
        pll_rst_seen = 1'b0;
        ticks_until(1, 1'b0, 100, n);
        chk("timeout_race_latency", n, STABLE_CYCLES + 3);
        chk("timeout_race_no_pll_rst", 32'(pll_rst_seen), 32'd0);
        chk("timeout_race_retry", 32'(retry_count), 32'(r0));

        for (int i = 0; i < 60; i++) begin
            pll_locked = ($urandom_range(0, 4) != 0);
            len = $urandom_range(1, 40);
            repeat (len) tick();
        end

        pll_locked = 1'b0;
        ticks_until(0, 1'b0, 100, n);
        ticks_until(0, 1'b1, 100, n);
        ticks_until(0, 1'b0, 100, n);
        chk("retry_pulse_width", n, RST_CYCLES);
        ticks_until(0, 1'b1, 100, n);
        chk("retry_pulse_gap", n, LOCK_TIMEOUT);
        repeat (260 * (RST_CYCLES + LOCK_TIMEOUT)) tick();
`ifdef PLL_RETRY_COUNT_EN
        chk("retry_saturated", 32'(retry_count), 32'd255);
`else
        chk("retry_tied_zero", 32'(retry_count), 32'd0);
`endif
        chk("no_lock_sys_rst", 32'(sys_rst), 32'd1);

        pll_locked = 1'b1;
        ticks_until(0, 1'b0, 100, n);
        repeat (5) tick();
        chk("mid_stable_sys_rst", 32'(sys_rst), 32'd1);
        #3 rst = 1'b1;
        #1 check_reset_values("async_stable");
        #2 rst = 1'b0;
        ticks_until(0, 1'b0, 50, n);
        chk("restart_pll_rst_width", n, RST_CYCLES);
        ticks_until(1, 1'b0, 100, n);
        chk("restart_release", n, STABLE_CYCLES + 1);

        tick();
        #3 rst = 1'b1;
        #1 check_reset_values("async_run");
        tick();
        rst = 1'b0;
        ticks_until(0, 1'b0, 50, n);
        chk("run_restart_pll_rst_width", n, RST_CYCLES);
        ticks_until(2, 1'b1, 100, n);
        chk("run_restart_ready", 32'(ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
